// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the queue entry layout and the NOP presented to decode when idle.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end signal bundle: imem req/gnt/rvalid port, EX redirect, decode port.
// master = fetch_queue side, slave = memory/pipeline environment side.
interface fetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall_d
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall_d
    );

endinterface

// File: rtl/fetch_queue_ring_buffer.sv
// Generic DEPTH-entry ring FIFO of fetch entries with synchronous clear.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller must not push when full unless popping.
module fetch_queue_ring_buffer
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    output fetch_entry_t  head_dat,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head_dat is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC gen, imem req/gnt+rvalid, buffered words to decode.
// Latency: grant N -> instr_valid N+2 (N+1 with FETCH_QUEUE_BYPASS_EN defined: empty-queue bypass).
// Backpressure: stall_d holds the head; requests stop once queued + outstanding words reach DEPTH.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]    DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]  MAXO_L  = CW'(MAX_OUTST);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_nxt;
    logic [CW-1:0] kill;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          run;
    logic          grant;
    logic          resp;
    logic          live;
    logic          bypass;
    logic          push;
    logic          pop;
    fetch_entry_t  push_dat;
    fetch_entry_t  head;

    // Every outstanding request owns a queue slot, so a returning word always fits.
    assign occupancy = {1'b0, count} + {1'b0, outst};
    assign bus.imem_req  = run && !bus.redirect && (outst < MAXO_L) && (occupancy < DEPTH_L);
    assign bus.imem_addr = fetch_pc;

    assign grant     = bus.imem_req && bus.imem_gnt;
    assign resp      = bus.imem_rvalid;
    assign live      = resp && (kill == '0);
    assign outst_nxt = outst + CW'(grant) - CW'(resp);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = live && (count == '0) && !bus.stall_d && !bus.redirect;
`else
    assign bypass = 1'b0;
`endif

    assign push     = live && !bus.redirect && !bypass;
    assign pop      = (count != '0) && !bus.stall_d && !bus.redirect;
    assign push_dat = '{pc: resp_pc, instr: bus.imem_rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            kill     <= '0;
        end else begin
            run   <= 1'b1;
            outst <= outst_nxt;
            if (bus.redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= word_align(bus.redirect_pc);
                resp_pc  <= word_align(bus.redirect_pc);
                kill     <= outst_nxt;
            end else begin
                if (grant)               fetch_pc <= fetch_pc + 32'd4;
                if (live)                resp_pc  <= resp_pc + 32'd4;
                if (resp && kill != '0)  kill     <= kill - 1'b1;
            end
        end
    end

    fetch_queue_ring_buffer #(.DEPTH(DEPTH)) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.redirect),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head),
        .count    (count)
    );

    always_comb begin
        bus.instr_valid = 1'b0;
        bus.instr       = NOP_INSTR;
        bus.instr_pc    = '0;
        if (count != '0) begin
            bus.instr_valid = 1'b1;
            bus.instr       = head.instr;
            bus.instr_pc    = head.pc;
        end else if (bypass) begin
            bus.instr_valid = 1'b1;
            bus.instr       = bus.imem_rdata;
            bus.instr_pc    = resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: randomized imem/stall/redirect stimulus checked against a
// program-order reference (expected consumed PC stream, expected fetch address stream).
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_consumed = 0;

    // memory model state
    logic [31:0] pend_addr [$];
    int          pend_rdy  [$];
    int          gnt_mode = 0;   // 0: always grant, 1: random, 2: never
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          rv_pct   = 100;

    // reference model state
    logic [31:0] exp_pc     = RESET_PC;
    logic [31:0] next_fetch = RESET_PC;
    logic        prev_wait  = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic        prev_hold  = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.stall_d     = 1'b0;
    end

    // Instruction memory: in-order responses, at least one cycle after each grant.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
            if (!rst) begin
                bus.imem_gnt = 1'b0;
            end else begin
                case (gnt_mode)
                    0:       bus.imem_gnt = 1'b1;
                    1:       bus.imem_gnt = 1'($urandom_range(0, 1));
                    default: bus.imem_gnt = 1'b0;
                endcase
                if (pend_addr.size() > 0 && pend_rdy[0] <= cyc && int'($urandom_range(0, 99)) < rv_pct) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_rdy.pop_front());
                end
            end
        end
    end

    // Reference checker: program-order PC stream, fetch address stream, handshake rules.
    always @(negedge clk) begin
        if (!rst) begin
            pend_addr.delete();
            pend_rdy.delete();
            exp_pc     = RESET_PC;
            next_fetch = RESET_PC;
            prev_wait  = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (bus.redirect) begin
                n_tests++;
                if (bus.imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_in_redirect: imem_req=%b required 0 (cycle %0d)", bus.imem_req, cyc);
                end
            end
            if (pend_addr.size() + (bus.imem_rvalid ? 1 : 0) >= MAX_OUTST) begin
                n_tests++;
                if (bus.imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL outst_limit: imem_req=%b required 0 with %0d outstanding (cycle %0d)",
                             bus.imem_req, pend_addr.size() + (bus.imem_rvalid ? 1 : 0), cyc);
                end
            end
            if (prev_wait && !bus.redirect) begin
                n_tests++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: req=%b addr=%h required req=1 addr=%h (cycle %0d)",
                             bus.imem_req, bus.imem_addr, prev_addr, cyc);
                end
            end
            if (prev_hold) begin
                n_tests++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== prev_pc || bus.instr !== prev_instr) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b pc=%h instr=%h required 1 %h %h (cycle %0d)",
                             bus.instr_valid, bus.instr_pc, bus.instr, prev_pc, prev_instr, cyc);
                end
            end
            if (bus.instr_valid !== 1'b1) begin
                n_tests++;
                if (bus.instr !== NOP_INSTR) begin
                    n_fail++;
                    $display("FAIL idle_nop: instr=%h required %h (cycle %0d)", bus.instr, NOP_INSTR, cyc);
                end
            end
            if (bus.instr_valid === 1'b1 && !bus.stall_d && !bus.redirect) begin
                n_tests++;
                if (bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL order: pc=%h instr=%h required pc=%h instr=%h (cycle %0d)",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc), cyc);
                end
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
                n_tests++;
                if (bus.imem_addr !== next_fetch) begin
                    n_fail++;
                    $display("FAIL grant_addr: addr=%h required %h (cycle %0d)", bus.imem_addr, next_fetch, cyc);
                end
                pend_addr.push_back(bus.imem_addr);
                pend_rdy.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                next_fetch = next_fetch + 32'd4;
            end
            if (bus.redirect) begin
                exp_pc     = {bus.redirect_pc[31:2], 2'b00};
                next_fetch = {bus.redirect_pc[31:2], 2'b00};
            end
            prev_wait  = bus.imem_req && !bus.imem_gnt && !bus.redirect;
            prev_addr  = bus.imem_addr;
            prev_hold  = bus.instr_valid && bus.stall_d && !bus.redirect;
            prev_pc    = bus.instr_pc;
            prev_instr = bus.instr;
        end
    end

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b required 0", bus.imem_req);
        end
        n_tests++;
        if (bus.instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b required 0", bus.instr_valid);
        end
        n_tests++;
        if (bus.instr !== NOP_INSTR) begin
            n_fail++; $display("FAIL reset_instr: got %h required %h", bus.instr, NOP_INSTR);
        end
        n_tests++;
        if (bus.instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h required 0", bus.instr_pc);
        end
    endtask

    task automatic test_latency();
        int g = -1;
        int v = -1;
        gnt_mode = 0; lat_min = 1; lat_max = 1; rv_pct = 100;
        @(posedge clk); #2 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin g = cyc; break; end
        end
        n_tests++;
        if (g < 0) begin
            n_fail++; $display("FAIL first_grant: no grant within 20 cycles, required one");
        end else begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.instr_valid === 1'b1) begin v = cyc; break; end
            end
            n_tests++;
            if (v < 0 || v - g != EXP_LAT) begin
                n_fail++; $display("FAIL first_latency: got %0d cycles required %0d", v - g, EXP_LAT);
            end
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RESET_PC + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL stream: valid=%b pc=%h required 1 %h", bus.instr_valid, bus.instr_pc,
                             RESET_PC + 32'(4 * i));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        @(posedge clk); #1 bus.stall_d = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_valid: got %b required 1", bus.instr_valid);
        end
        held = bus.instr_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== held) begin
                n_fail++; $display("FAIL stall_held_pc: pc=%h required %h", bus.instr_pc, held);
            end
        end
        n_tests++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_req_drop: imem_req=%b required 0 with queue full", bus.imem_req);
        end
        @(posedge clk); #1 bus.stall_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== held + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stall_release: valid=%b pc=%h required 1 %h", bus.instr_valid, bus.instr_pc,
                         held + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_outst();
        bit found = 0;
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (pend_addr.size() == 2) begin found = 1; break; end
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL redir_setup: outstanding never reached 2, required 2");
        end
        @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100;
        @(posedge clk); #1 bus.redirect = 1'b0;
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1) begin found = 1; break; end
        end
        n_tests++;
        if (!found || bus.instr_pc !== 32'h0000_0100) begin
            n_fail++; $display("FAIL redir_first_pc: valid=%b pc=%h required 1 00000100", found, bus.instr_pc);
        end
    endtask

    task automatic test_gnt_wait();
        logic [31:0] a0;
        gnt_mode = 2;
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.imem_req !== 1'b1) begin
            n_fail++; $display("FAIL gntw_req: imem_req=%b required 1", bus.imem_req);
        end
        a0 = bus.imem_addr;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== a0) begin
                n_fail++; $display("FAIL gntw_stable: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, a0);
            end
        end
        @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100;
        @(negedge clk);
        n_tests++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL gntw_withdraw: imem_req=%b required 0", bus.imem_req);
        end
        @(posedge clk); #1 bus.redirect = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL gntw_reissue: req=%b addr=%h required 1 00000100", bus.imem_req, bus.imem_addr);
        end
        gnt_mode = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        int k = 0;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFB;
        @(posedge clk); #1 bus.redirect = 1'b0;
        for (int i = 0; i < 30 && k < 3; i++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1 && !bus.stall_d) begin
                n_tests++;
                if (bus.instr_pc !== want[k]) begin
                    n_fail++; $display("FAIL wrap_pc[%0d]: got %h required %h", k, bus.instr_pc, want[k]);
                end
                k++;
            end
        end
        n_tests++;
        if (k != 3) begin
            n_fail++; $display("FAIL wrap_timeout: got %0d words required 3", k);
        end
    endtask

    task automatic test_random();
        int c0;
        gnt_mode = 1; lat_min = 1; lat_max = 3; rv_pct = 70;
        c0 = n_consumed;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            bus.stall_d = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            end else begin
                bus.redirect = 1'b0;
            end
        end
        @(posedge clk); #1 bus.stall_d = 1'b0; bus.redirect = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++;
        if (n_consumed - c0 < 40) begin
            n_fail++; $display("FAIL random_progress: consumed %0d words required >= 40", n_consumed - c0);
        end
    endtask

    task automatic test_reset_midburst();
        bit found = 0;
        repeat (10) @(negedge clk);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        n_tests++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== NOP_INSTR || bus.instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_out: valid=%b instr=%h pc=%h required 0 %h 0", bus.instr_valid, bus.instr,
                     bus.instr_pc, NOP_INSTR);
        end
        n_tests++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL midreset_req: got %b required 0", bus.imem_req);
        end
        @(posedge clk); #2 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin found = 1; break; end
        end
        n_tests++;
        if (!found || bus.imem_addr !== RESET_PC) begin
            n_fail++; $display("FAIL midreset_first_req: req=%b addr=%h required 1 %h", found, bus.imem_addr, RESET_PC);
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_redirect_outst();
        test_gnt_wait();
        test_wrap();
        test_random();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
